iicmb_wb_sequencer: RTL

Hardware command sequencer that drives the IICMB I2C multi-bus controller through its Wishbone slave port. It turns one high-level transaction request into the full register-level command sequence: set bus, start, address byte, N data bytes, stop. The request carries bus number, 7-bit address, direction and byte count. The block sits between on-chip requesters and the IICMB core, replacing the task-level register programming the testbench performs today.

---
 rtl/iicmb_wb_sequencer.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iicmb_wb_sequencer.sv
// Wishbone master that expands one I2C transaction request into the IICMB
// register command sequence: set bus, start, address, data bytes, stop.
module iicmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 5,
  parameter int IRQ_TIMEOUT    = 100000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rnw,
  input  logic [WB_DATA_WIDTH-1:0]  req_bus,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]      req_len,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [WB_DATA_WIDTH-1:0]  wdata,
  output logic                      rdata_valid,
  input  logic                      rdata_ready,
  output logic [WB_DATA_WIDTH-1:0]  rdata,
  output logic                      done,
  output logic [2:0]                status,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  localparam int TMO_W = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IRQ_TIMEOUT - 1);

  localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2,
                         ST_ERR = 3'd3, ST_TMO = 3'd4;

  localparam logic [2:0] CMD_SET_BUS  = 3'b110, CMD_START    = 3'b100,
                         CMD_WRITE    = 3'b001, CMD_READ_ACK = 3'b010,
                         CMD_READ_NAK = 3'b011, CMD_STOP     = 3'b101;

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);
  localparam logic [WB_DATA_WIDTH-1:0] CSR_INIT = WB_DATA_WIDTH'(8'hC0);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_BUS, S_START, S_ADDR, S_DATA_FETCH,
    S_DATA_CMD, S_RD_DPR, S_RD_OUT, S_STOP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SUB_WR_DPR, SUB_WR_CMD, SUB_WAIT_IRQ, SUB_RD_ST
  } sub_t;

  state_t                    state;
  sub_t                      sub;
  logic                      lat_rnw;
  logic [WB_DATA_WIDTH-1:0]  lat_bus;
  logic [I2C_ADDR_WIDTH-1:0] lat_addr;
  logic [WB_DATA_WIDTH-1:0]  wbyte;
  logic [LEN_WIDTH-1:0]      cnt;
  logic [TMO_W-1:0]          tmo;
  logic                      nak_seen;

  logic                      has_dpr;
  logic [WB_DATA_WIDTH-1:0]  dpr_val;
  logic [2:0]                cmd_code;
  logic                      bus_req;
  logic                      acc_we;
  logic [WB_ADDR_WIDTH-1:0]  acc_adr;
  logic [WB_DATA_WIDTH-1:0]  acc_dat;
  logic                      bus_ack;
  logic                      last_byte;

  assign bus_ack   = cyc_o && ack_i;
  assign last_byte = (cnt == LEN_WIDTH'(1));

  // Operands of the IICMB command for the current state, and the bus access it needs now
  always_comb begin
    has_dpr  = 1'b0;
    dpr_val  = '0;
    cmd_code = CMD_STOP;
    bus_req  = 1'b0;
    acc_we   = 1'b0;
    acc_adr  = ADR_CSR;
    acc_dat  = '0;
    case (state)
      S_BUS:   begin has_dpr = 1'b1; dpr_val = lat_bus; cmd_code = CMD_SET_BUS; end
      S_START: cmd_code = CMD_START;
      S_ADDR:  begin
        has_dpr  = 1'b1;
        dpr_val  = WB_DATA_WIDTH'({lat_addr, lat_rnw});
        cmd_code = CMD_WRITE;
      end
      S_DATA_CMD: begin
        if (lat_rnw) begin
          cmd_code = last_byte ? CMD_READ_NAK : CMD_READ_ACK;
        end else begin
          has_dpr  = 1'b1;
          dpr_val  = wbyte;
          cmd_code = CMD_WRITE;
        end
      end
      default: ;
    endcase
    case (state)
      S_INIT:   begin bus_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CSR; acc_dat = CSR_INIT; end
      S_RD_DPR: begin bus_req = 1'b1; acc_adr = ADR_DPR; end
      S_BUS, S_START, S_ADDR, S_DATA_CMD, S_STOP: begin
        case (sub)
          SUB_WR_DPR: begin bus_req = has_dpr; acc_we = 1'b1; acc_adr = ADR_DPR; acc_dat = dpr_val; end
          SUB_WR_CMD: begin
            bus_req = 1'b1;
            acc_we  = 1'b1;
            acc_adr = ADR_CMDR;
            acc_dat = WB_DATA_WIDTH'(cmd_code);
          end
          SUB_RD_ST:  begin bus_req = 1'b1; acc_adr = ADR_CMDR; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_INIT;
      sub         <= SUB_WR_DPR;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      status      <= ST_OK;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      nak_seen    <= 1'b0;
      tmo         <= '0;
    end else begin
      done <= 1'b0;
      // Bus engine: a new access may only start from an idle bus, so the ack edge always leaves a gap
      if (bus_ack) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
        adr_o <= '0;
        dat_o <= '0;
      end else if (bus_req && !cyc_o) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= acc_we;
        adr_o <= acc_adr;
        dat_o <= acc_dat;
      end

      case (state)
        S_INIT: if (bus_ack) begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        S_IDLE: if (req_valid && req_ready) begin
          lat_rnw   <= req_rnw;
          lat_bus   <= req_bus;
          lat_addr  <= req_addr;
          cnt       <= req_len;
          req_ready <= 1'b0;
          nak_seen  <= 1'b0;
          sub       <= SUB_WR_DPR;
          state     <= S_BUS;
        end
        S_DATA_FETCH: begin
          if (wdata_ready && wdata_valid) begin
            wbyte       <= wdata;
            wdata_ready <= 1'b0;
            sub         <= SUB_WR_DPR;
            state       <= S_DATA_CMD;
          end else if (wdata_valid) begin
            wdata_ready <= 1'b1;
          end
        end
        S_RD_DPR: if (bus_ack) begin
          rdata       <= dat_i;
          rdata_valid <= 1'b1;
          state       <= S_RD_OUT;
        end
        S_RD_OUT: if (rdata_ready) begin
          rdata_valid <= 1'b0;
          cnt         <= cnt - 1'b1;
          sub         <= SUB_WR_DPR;
          state       <= last_byte ? S_STOP : S_DATA_CMD;
        end
        S_DONE: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          case (sub)
            SUB_WR_DPR: if (!has_dpr || bus_ack) sub <= SUB_WR_CMD;
            SUB_WR_CMD: if (bus_ack) begin
              sub <= SUB_WAIT_IRQ;
              tmo <= '0;
            end
            SUB_WAIT_IRQ: begin
              if (irq_i) begin
                sub <= SUB_RD_ST;
              end else if (tmo == TMO_LAST) begin
                done   <= 1'b1;
                status <= ST_TMO;
                sub    <= SUB_WR_DPR;
                state  <= S_INIT;
              end else begin
                tmo <= tmo + 1'b1;
              end
            end
            SUB_RD_ST: if (bus_ack) begin
              sub <= SUB_WR_DPR;
              // Status byte: [7] DON, [6] NAK, [5] AL, [4] ERR
              if (dat_i[5]) begin
                done <= 1'b1; status <= ST_AL; state <= S_DONE;
              end else if (dat_i[4] || !(dat_i[7] || dat_i[6])) begin
                done <= 1'b1; status <= ST_ERR; state <= S_DONE;
              end else if (dat_i[6] && state != S_STOP) begin
                nak_seen <= 1'b1;
                state    <= S_STOP;
              end else begin
                case (state)
                  S_BUS:   state <= S_START;
                  S_START: state <= S_ADDR;
                  S_ADDR: begin
                    if (cnt == '0)   state <= S_STOP;
                    else if (lat_rnw) state <= S_DATA_CMD;
                    else              state <= S_DATA_FETCH;
                  end
                  S_DATA_CMD: begin
                    if (lat_rnw) begin
                      state <= S_RD_DPR;
                    end else begin
                      cnt   <= cnt - 1'b1;
                      state <= last_byte ? S_STOP : S_DATA_FETCH;
                    end
                  end
                  default: begin
                    done   <= 1'b1;
                    status <= (nak_seen || dat_i[6]) ? ST_NAK : ST_OK;
                    state  <= S_DONE;
                  end
                endcase
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule
